// File: rtl/spi_rx_word_buffer_pkg.sv
// rtl/spi_rx_word_buffer_pkg.sv - shared types and lane mapping for spi_rx_word_buffer
// Lane order follows SPI_RX_BIG_ENDIAN_EN (undefined: little-endian).
package spi_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_VALID = 2'd1,
      ST_GAP   = 2'd2
   } out_state_e;

   function automatic int bytes_per_word(input int data_width);
      return data_width / 8;
   endfunction

   function automatic int lane_idx(input int cnt, input int bpw);
`ifdef SPI_RX_BIG_ENDIAN_EN
      return (bpw - 1) - cnt;
`else
      return cnt % bpw;
`endif
   endfunction

endpackage

// File: rtl/spi_rx_word_buffer_if.sv
// rtl/spi_rx_word_buffer_if.sv - byte input and word handshake bundle
// master: the word buffer; slave: the byte source plus downstream consumer.
interface spi_rx_word_buffer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  i_rx_valid;
   logic [7:0]            i_rx_byte;
   logic                  i_frame_start;
   logic                  o_DV;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  i_fifo_en;

   modport master (
      input  i_rx_valid, i_rx_byte, i_frame_start, i_fifo_en,
      output o_DV, o_data
   );

   modport slave (
      output i_rx_valid, i_rx_byte, i_frame_start, i_fifo_en,
      input  o_DV, o_data
   );
endinterface

// File: rtl/spi_rx_sync_fifo.sv
// rtl/spi_rx_sync_fifo.sv - single-clock FIFO with level, full and empty
// A write while full is accepted only when a read frees a slot on the same edge.
module spi_rx_sync_fifo #(
   parameter int DW = 32,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);

   logic [DW-1:0] mem_q [0:(1<<AW)-1];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          do_wr, do_rd;

   assign full    = (level_q == {1'b1, {AW{1'b0}}});
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];

   assign do_wr = wr_en & (~full | rd_en);
   assign do_rd = rd_en & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/spi_rx_word_buffer.sv
// rtl/spi_rx_word_buffer.sv - packs SPI bytes into words, queues them, presents one at a time
// SPI_RX_BIG_ENDIAN_EN selects first-byte-in-MSB lane order.
module spi_rx_word_buffer
   import spi_rx_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH),
   parameter int ADDR_WIDTH     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   spi_rx_word_buffer_if.master   bus,
   output logic [ADDR_WIDTH:0]    o_level,
   output logic                   o_full,
   output logic                   o_overflow
);

   localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_WORD - 1);

   logic [CNT_W-1:0]      cnt_q, cnt_d, base_cnt;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic                  wr_q, wr_d;
   int                    lane;

   out_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  overflow_q, overflow_d;
   logic                  pop;

   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic [ADDR_WIDTH:0]   fifo_level;
   logic                  fifo_full, fifo_empty;

   // A frame start coinciding with a byte makes that byte lane 0 of the fresh word.
   always_comb begin
      cnt_d    = cnt_q;
      word_d   = word_q;
      wr_d     = 1'b0;
      lane     = 0;
      base_cnt = bus.i_frame_start ? '0 : cnt_q;
      if (bus.i_frame_start) cnt_d = '0;
      if (bus.i_rx_valid) begin
         lane = lane_idx(int'(base_cnt), BYTES_PER_WORD);
         word_d[lane*8 +: 8] = bus.i_rx_byte;
         if (base_cnt == LAST_CNT) begin
            cnt_d = '0;
            wr_d  = 1'b1;
         end else begin
            cnt_d = base_cnt + 1'b1;
         end
      end
   end

   spi_rx_sync_fifo #(
      .DW (DATA_WIDTH),
      .AW (ADDR_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_q),
      .wr_data (word_q),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .level   (fifo_level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // GAP forces one low cycle of o_DV between words so the consumer can re-arm.
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_d = ST_VALID;
               data_d  = fifo_rd_data;
            end
         end
         ST_VALID: begin
            if (bus.i_fifo_en) begin
               pop     = 1'b1;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (!fifo_empty) begin
               state_d = ST_VALID;
               data_d  = fifo_rd_data;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      overflow_d = overflow_q | (wr_q & fifo_full & ~pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         word_q     <= '0;
         wr_q       <= 1'b0;
         state_q    <= ST_IDLE;
         data_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         wr_q       <= wr_d;
         state_q    <= state_d;
         data_q     <= data_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.o_DV   = (state_q == ST_VALID);
   assign bus.o_data = data_q;
   assign o_level    = fifo_level;
   assign o_full     = fifo_full;
   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_spi_rx_word_buffer.sv
// tb/tb_spi_rx_word_buffer.sv - scoreboard bench for spi_rx_word_buffer
// Expected words queue up as bytes are sent and are compared at each o_DV rise.
module tb_spi_rx_word_buffer;

   localparam int DW = 32;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_rx_word_buffer_if #(.DATA_WIDTH(DW)) bus ();
   logic [AW:0] o_level;
   logic        o_full;
   logic        o_overflow;

   spi_rx_word_buffer #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .o_level    (o_level),
      .o_full     (o_full),
      .o_overflow (o_overflow)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] sb[$];
   logic [DW-1:0] last_data;
   logic [AW:0]   gap_level;
   bit auto_pop = 0, lvl_chk = 0, dv_hold = 0;
   bit dv_prev = 0, popped_last = 0, gap_pend = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack4(input logic [31:0] raw);
`ifdef SPI_RX_BIG_ENDIAN_EN
      return {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
`else
      return raw;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic fs);
      bus.i_rx_valid    = 1'b1;
      bus.i_rx_byte     = b;
      bus.i_frame_start = fs;
      tick();
      bus.i_rx_valid    = 1'b0;
      bus.i_frame_start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] raw, input bit expect_it);
      for (int i = 0; i < 4; i++) send_byte(raw[8*i +: 8], 1'b0);
      if (expect_it) sb.push_back(pack4(raw));
   endtask

   task automatic wait_drain(input string tag);
      int n;
      for (n = 0; n < 600; n++) begin
         if (sb.size() == 0 && o_level == 0 && !bus.o_DV) break;
         tick();
      end
      check_eq(tag, (n < 600), 1);
      auto_pop      = 0;
      bus.i_fifo_en = 1'b0;
   endtask

   task automatic do_reset();
      rst               = 1'b1;
      auto_pop          = 0;
      bus.i_rx_valid    = 1'b0;
      bus.i_frame_start = 1'b0;
      bus.i_fifo_en     = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic check_reset_vals(input string pfx);
      check_eq({pfx, "_dv"},   bus.o_DV,   0);
      check_eq({pfx, "_data"}, bus.o_data, 0);
      check_eq({pfx, "_lvl"},  o_level,    0);
      check_eq({pfx, "_full"}, o_full,     0);
      check_eq({pfx, "_ovf"},  o_overflow, 0);
   endtask

   // Monitor: word order, o_data stability, and the single low cycle after each pop.
   initial forever begin
      logic [DW-1:0] exp_w;
      @(negedge clk);
      if (rst) begin
         dv_prev = 0; popped_last = 0; gap_pend = 0;
      end else begin
         if (gap_pend) begin
            gap_pend = 0;
            if (gap_level != 0) check_eq("gap_one_cycle", bus.o_DV, 1);
         end
         if (popped_last) begin
            popped_last = 0;
            check_eq("gap_low", bus.o_DV, 0);
            gap_level = o_level;
            gap_pend  = 1;
         end
         if (bus.o_DV && dv_prev) check_eq("data_stable", bus.o_data, last_data);
         if (bus.o_DV && !dv_prev) begin
            if (sb.size() == 0) begin
               check_eq("sb_underflow", sb.size(), 1);
            end else begin
               exp_w = sb.pop_front();
               if (lvl_chk) check_eq("level_at_rise", o_level, sb.size() + 1);
               check_eq("word", bus.o_data, exp_w);
            end
         end
         if (bus.o_DV && bus.i_fifo_en) popped_last = 1;
         dv_prev   = bus.o_DV;
         last_data = bus.o_data;
      end
   end

   // Consumer: pulse i_fifo_en once o_DV has been high for a full cycle.
   initial forever begin
      @(posedge clk);
      #1;
      if (auto_pop) begin
         if (bus.o_DV && dv_hold && !bus.i_fifo_en) bus.i_fifo_en = 1'b1;
         else                                       bus.i_fifo_en = 1'b0;
         dv_hold = bus.o_DV;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      bus.i_rx_valid    = 1'b0;
      bus.i_rx_byte     = 8'h00;
      bus.i_frame_start = 1'b0;
      bus.i_fifo_en     = 1'b0;
      do_reset();
      @(negedge clk);
      check_reset_vals("rst");
      tick();

      // First word latency and hold
      send_word(32'h44332211, 1);
      @(negedge clk);
      check_eq("lat_e0_dv", bus.o_DV, 0);
      @(negedge clk);
      check_eq("lat_e1_dv", bus.o_DV, 0);
      check_eq("lat_e1_lvl", o_level, 1);
      @(negedge clk);
      check_eq("lat_e2_dv", bus.o_DV, 1);
      check_eq("lat_e2_data", bus.o_data, pack4(32'h44332211));
      check_eq("lat_e2_lvl", o_level, 1);
      repeat (3) @(negedge clk);
      check_eq("hold_dv", bus.o_DV, 1);
      tick();
      dv_hold = 0; auto_pop = 1;
      wait_drain("drain_first");

      // Frame start discards partial words
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      bus.i_frame_start = 1'b1;
      tick();
      bus.i_frame_start = 1'b0;
      send_word(32'h04030201, 1);
      send_byte(8'h55, 1'b0);
      send_byte(8'hA1, 1'b1);
      send_byte(8'hA2, 1'b0);
      send_byte(8'hA3, 1'b0);
      send_byte(8'hA4, 1'b0);
      sb.push_back(pack4(32'hA4A3A2A1));
      dv_hold = 0; auto_pop = 1;
      wait_drain("drain_frame");

      // Eight queued words drained with level tracking
      for (int i = 0; i < 8; i++) begin
         r = $urandom;
         send_word(r, 1);
      end
      repeat (3) tick();
      check_eq("eight_level", o_level, 8);
      lvl_chk = 1; dv_hold = 0; auto_pop = 1;
      wait_drain("drain_eight");
      lvl_chk = 0;

      // Overflow when full without a pop
      for (int i = 0; i < 16; i++) begin
         r = $urandom;
         send_word(r, 1);
      end
      repeat (2) tick();
      check_eq("fill_level", o_level, 16);
      check_eq("fill_full", o_full, 1);
      check_eq("fill_ovf", o_overflow, 0);
      r = $urandom;
      send_word(r, 0);
      repeat (2) tick();
      check_eq("ovf_set", o_overflow, 1);
      check_eq("ovf_level", o_level, 16);
      check_eq("ovf_full", o_full, 1);
      dv_hold = 0; auto_pop = 1;
      wait_drain("drain_ovf");
      check_eq("ovf_sticky", o_overflow, 1);
      check_eq("ovf_not_full", o_full, 0);
      do_reset();
      @(negedge clk);
      check_eq("ovf_cleared", o_overflow, 0);
      tick();

      // Write coinciding with a pop while full
      for (int i = 0; i < 16; i++) begin
         r = $urandom;
         send_word(r, 1);
      end
      repeat (2) tick();
      check_eq("co_level_pre", o_level, 16);
      check_eq("co_dv_pre", bus.o_DV, 1);
      r = $urandom;
      send_byte(r[7:0], 1'b0);
      send_byte(r[15:8], 1'b0);
      send_byte(r[23:16], 1'b0);
      send_byte(r[31:24], 1'b0);
      bus.i_fifo_en = 1'b1;
      tick();
      bus.i_fifo_en = 1'b0;
      sb.push_back(pack4(r));
      @(negedge clk);
      check_eq("co_level", o_level, 16);
      check_eq("co_full", o_full, 1);
      check_eq("co_ovf", o_overflow, 0);
      tick();
      dv_hold = 0; auto_pop = 1;
      wait_drain("drain_co");
      check_eq("co_ovf_end", o_overflow, 0);

      // Reset mid-word and mid-VALID, then a clean word
      r = $urandom;
      send_word(r, 1);
      repeat (3) tick();
      check_eq("mid_valid", bus.o_DV, 1);
      send_byte(8'hC1, 1'b0);
      send_byte(8'hC2, 1'b0);
      do_reset();
      @(negedge clk);
      check_reset_vals("rst_mid");
      tick();
      send_word(32'hD4D3D2D1, 1);
      dv_hold = 0; auto_pop = 1;
      wait_drain("drain_after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
